// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle radix-2 shift-add multiplier controller for the EX stage
module mul_sequencer #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [2:0]       alu_control,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;
    logic             start;
    logic             last;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mplier_next;

    // start is built from EX inputs only, so it cannot loop back through stall
    assign start       = ex_valid && alu_control == 3'b101 && !flush;
    assign acc_next    = mplier[0] ? acc + mcand : acc;
    assign mplier_next = mplier >> 1;
    assign last        = count == CW'(WIDTH - 1) || (EARLY_EXIT && mplier_next == '0);
    assign stall       = (state == IDLE && start) || state == BUSY;
    assign done        = state == DONE;

    // Sequencer: capture operands, iterate one multiplier bit per cycle, publish product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            result <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mcand  <= op_a;
                    mplier <= op_b;
                    acc    <= '0;
                    count  <= '0;
                    state  <= BUSY;
                end
                BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier_next;
                    count  <= count + CW'(1);
                    if (last) begin
                        state  <= DONE;
                        result <= acc_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
